fp_keystream_gen: RTL and testbench

- Downstream consumer of the FP divider/chaotic-map datapath.
- Accepts IEEE-754 values produced by FP_div and quantises each to an 8-bit key byte: floor(|x|·2^KEY_SHIFT) mod 256.
- Buffers key bytes in a show-ahead FIFO and presents them with valid/ready to the pixel XOR/permutation stage.

---
 rtl/fp_keystream_gen.sv | 158 +++++++++++++++
 tb/tb_fp_keystream_gen.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_keystream_gen.sv
// fp_keystream_gen: quantises IEEE-754 values to key bytes floor(|x|*2^KEY_SHIFT) mod 256,
// buffered in a show-ahead FIFO. Ports: in_valid/in_ready/in_data in, key_valid/key_ready/
// key_byte/key_special out, fifo_count. Optional macro KEYSTREAM_SIGN_MIX_EN: invert byte for negatives.
module fp_keystream_gen #(
  parameter int PRECISION = 32,
  parameter int EXPONENT  = 8,
  parameter int FRACTION  = 23,
  parameter int KEY_SHIFT = 16,
  parameter int DEPTH     = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PRECISION-1:0]       in_data,
  output logic                       key_valid,
  input  logic                       key_ready,
  output logic [7:0]                 key_byte,
  output logic                       key_special,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int AW   = $clog2(DEPTH);
  localparam int SW   = EXPONENT + 2;
  localparam int BIAS = 2**(EXPONENT-1) - 1;

  logic                accept;
  logic [EXPONENT-1:0] e_in;
  logic [SW-1:0]       sh_d;

  logic                s1_v_q, s1_s_q, s1_zero_q, s1_spec_q;
  logic [FRACTION:0]   s1_m_q;
  logic [SW-1:0]       s1_sh_q;

  logic                s2_v_q, s2_spec_q;
  logic [7:0]          s2_b_q;
  logic [7:0]          b_d;
  logic                spec_d;
  logic [SW-1:0]       nsh;
  logic                sh_neg, sh_big, r_far;

  logic [8:0]          mem [DEPTH];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [AW:0]         count_q, count_d;
  logic [8:0]          last_q;
  logic                push, pop;
  logic [AW+1:0]       occ;

  // Credit check uses registers only, so key_ready never reaches in_ready.
  assign occ      = {1'b0, count_q} + (AW+2)'(s1_v_q) + (AW+2)'(s2_v_q);
  assign in_ready = occ < (AW+2)'(DEPTH);
  assign accept   = in_valid && in_ready;

  assign e_in = in_data[PRECISION-2 -: EXPONENT];
  assign sh_d = SW'(int'(e_in) - BIAS - FRACTION + KEY_SHIFT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_v_q    <= 1'b0;
      s1_s_q    <= 1'b0;
      s1_zero_q <= 1'b0;
      s1_spec_q <= 1'b0;
      s1_m_q    <= '0;
      s1_sh_q   <= '0;
    end else begin
      s1_v_q <= accept;
      if (accept) begin
        s1_s_q    <= in_data[PRECISION-1];
        s1_zero_q <= (e_in == '0);
        s1_spec_q <= (e_in == '1);
        s1_m_q    <= {1'b1, in_data[FRACTION-1:0]};
        s1_sh_q   <= sh_d;
      end
    end
  end

  assign sh_neg = s1_sh_q[SW-1];
  assign sh_big = !sh_neg && (s1_sh_q[SW-2:3] != '0);
  assign nsh    = '0 - s1_sh_q;
  assign r_far  = nsh >= SW'(FRACTION + 1);

  always_comb begin
    b_d    = '0;
    spec_d = 1'b0;
    if (s1_zero_q) begin
      b_d = '0;
    end else if (s1_spec_q) begin
      spec_d = 1'b1;
    end else if (sh_big) begin
      b_d = '0;
    end else if (!sh_neg) begin
      b_d = s1_m_q[7:0] << s1_sh_q[2:0];
    end else if (r_far) begin
      b_d = '0;
    end else begin
      b_d = 8'(s1_m_q >> nsh);
    end
`ifdef KEYSTREAM_SIGN_MIX_EN
    if (s1_s_q && !s1_zero_q && !s1_spec_q) begin
      b_d = b_d ^ 8'hFF;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_v_q    <= 1'b0;
      s2_spec_q <= 1'b0;
      s2_b_q    <= '0;
    end else begin
      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        s2_spec_q <= spec_d;
        s2_b_q    <= b_d;
      end
    end
  end

  assign push = s2_v_q;
  assign pop  = key_valid && key_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= {s2_spec_q, s2_b_q};
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        last_q   <= mem[rd_ptr_q];
      end
    end
  end

  // When empty, show the last popped entry rather than a stale slot.
  assign key_valid                 = (count_q != '0);
  assign {key_special, key_byte}   = key_valid ? mem[rd_ptr_q] : last_q;
  assign fifo_count                = count_q;

endmodule

// File: tb/tb_fp_keystream_gen.sv
// tb_fp_keystream_gen: table vectors plus corner sequences,
// checked through a scoreboard queue against fp_keystream_gen.
module tb_fp_keystream_gen;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       key_ready = 1'b0;
  logic [31:0] in_data = '0;
  logic       in_ready, key_valid, key_special;
  logic [7:0] key_byte;
  logic [3:0] fifo_count;

  int checks = 0;
  int errors = 0;
  logic [8:0] sbq [$];

`ifdef KEYSTREAM_SIGN_MIX_EN
  localparam bit SM = 1'b1;
`else
  localparam bit SM = 1'b0;
`endif

  typedef struct {
    logic [31:0] d;
    logic [7:0]  b;
    logic [7:0]  bsm;
    logic        s;
  } vec_t;
  vec_t tbl [$];

  fp_keystream_gen dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .key_valid(key_valid), .key_ready(key_ready),
    .key_byte(key_byte), .key_special(key_special),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [8:0] model(input logic [31:0] d);
    int e, sh;
    logic [23:0] m;
    logic [7:0] b;
    e = int'(d[30:23]);
    if (e == 0) return 9'h000;
    if (e == 255) return 9'h100;
    m = {1'b1, d[22:0]};
    sh = e - 134;
    if (sh >= 8) b = 8'h00;
    else if (sh >= 0) b = 8'((32'(m)) << sh);
    else if (-sh >= 24) b = 8'h00;
    else b = 8'(m >> (-sh));
    if (SM && d[31]) b = b ^ 8'hFF;
    return {1'b0, b};
  endfunction

  function automatic logic [31:0] rnd_val();
    logic [7:0] e;
    e = 8'(120 + $urandom_range(0, 25));
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  always @(negedge clk) begin
    if (reset_n) begin
      chk("count_max", 32'(fifo_count <= 4'd8), 32'd1);
      if (key_valid && key_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: got 0x%0h expected none",
                   {key_special, key_byte});
        end else begin
          chk("key_out", 32'({key_special, key_byte}),
              32'(sbq.pop_front()));
        end
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic [8:0] e);
    int n;
    in_data = d;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 expected 1");
    end else begin
      sbq.push_back(e);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sbq.size() != 0 || key_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_sb", 32'(sbq.size()), 32'd0);
    chk("drain_count", 32'(fifo_count), 32'd0);
  endtask

  task automatic add(input logic [31:0] d, input logic [7:0] b,
                     input logic [7:0] bsm, input logic s);
    vec_t v;
    v.d = d;
    v.b = b;
    v.bsm = bsm;
    v.s = s;
    tbl.push_back(v);
  endtask

  initial begin
    int n;
    add(32'h7F800000, 8'h00, 8'h00, 1'b1);
    add(32'h7FC00000, 8'h00, 8'h00, 1'b1);
    add(32'h3FD55555, 8'hAA, 8'hAA, 1'b0);
    add(32'h41A00000, 8'h00, 8'h00, 1'b0);
    add(32'h00000000, 8'h00, 8'h00, 1'b0);
    add(32'h47800000, 8'h00, 8'h00, 1'b0);
    add(32'h3A800000, 8'h40, 8'h40, 1'b0);
    add(32'hBA800000, 8'h40, 8'hBF, 1'b0);
    add(32'h00400000, 8'h00, 8'h00, 1'b0);
    add(32'h80400000, 8'h00, 8'h00, 1'b0);
    add(32'h80000000, 8'h00, 8'h00, 1'b0);
    add(32'h37800000, 8'h01, 8'h01, 1'b0);
    add(32'h37000000, 8'h00, 8'h00, 1'b0);
    add(32'h3C7F0000, 8'hFC, 8'hFC, 1'b0);
    add(32'h46800001, 8'h80, 8'h80, 1'b0);
    add(32'h47000001, 8'h00, 8'h00, 1'b0);
    add(32'hC7000001, 8'h00, 8'hFF, 1'b0);
    add(32'hFF800000, 8'h00, 8'h00, 1'b1);
    add(32'h3F924925, 8'h92, 8'h92, 1'b0);

    #2;
    chk("rst_key_valid", 32'(key_valid), 32'd0);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_key_byte", 32'(key_byte), 32'd0);
    chk("rst_key_special", 32'(key_special), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    sync();
    key_ready = 1'b1;
    send(32'hBF924925, SM ? 9'h06D : 9'h092);
    @(negedge clk);
    chk("lat_edge1", 32'(key_valid), 32'd0);
    @(negedge clk);
    chk("lat_edge2", 32'(key_valid), 32'd0);
    @(negedge clk);
    chk("lat_edge3", 32'(key_valid), 32'd1);
    @(negedge clk);
    chk("hold_valid", 32'(key_valid), 32'd0);
    chk("hold_byte", 32'(key_byte), SM ? 32'h6D : 32'h92);
    chk("hold_special", 32'(key_special), 32'd0);

    sync();
    foreach (tbl[i]) begin
      send(tbl[i].d, {tbl[i].s, SM ? tbl[i].bsm : tbl[i].b});
    end
    wait_drain();

    sync();
    key_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          logic [31:0] v;
          v = rnd_val();
          send(v, model(v));
        end
      end
      begin
        repeat (14) @(negedge clk);
        chk("full_count", 32'(fifo_count), 32'd8);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_pending", 32'(sbq.size()), 32'd8);
        key_ready = 1'b1;
      end
    join
    wait_drain();

    sync();
    key_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 28; i++) begin
          logic [31:0] v;
          v = rnd_val();
          send(v, model(v));
        end
      end
      begin
        n = 0;
        while (fifo_count != 4'd4 && n < 100) begin
          @(negedge clk);
          n++;
        end
        chk("steady_reach", 32'(fifo_count), 32'd4);
        key_ready = 1'b1;
        repeat (20) begin
          @(negedge clk);
          chk("steady_count", 32'(fifo_count), 32'd4);
        end
      end
    join
    wait_drain();

    sync();
    key_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      logic [31:0] v;
      v = rnd_val();
      send(v, model(v));
    end
    chk("pre_rst_count", 32'(fifo_count), 32'd5);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(key_valid), 32'd0);
    chk("mid_rst_count", 32'(fifo_count), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    sbq.delete();
    @(negedge clk);
    reset_n = 1'b1;
    sync();
    key_ready = 1'b1;
    send(32'h3C7F0000, 9'h0FC);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
